// File: rtl/fullconnect_mst_arbiter.sv
// Two-to-one Avalon master arbiter: read and write slave ports share one Avalon master.
// Define FC_ARB_LOCK_EN to honour the per-side lock inputs; default build ignores them.
module fullconnect_mst_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 512,
  parameter int BE_WIDTH   = 64,
  parameter int MAX_HOLD   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  // read-side slave
  input  logic [ADDR_WIDTH-1:0] RdMstAddr_i,
  input  logic                  RdMstRead_i,
  input  logic [BE_WIDTH-1:0]   RdMstByteEnable_i,
  input  logic                  RdMstLock_i,
  output logic [DATA_WIDTH-1:0] RdMstReadData_o,
  output logic                  RdMstWaitReq_o,
  // write-side slave
  input  logic [ADDR_WIDTH-1:0] WrMstAddr_i,
  input  logic                  WrMstWrite_i,
  input  logic [BE_WIDTH-1:0]   WrMstByteEnable_i,
  input  logic [DATA_WIDTH-1:0] WrMstWriteData_i,
  input  logic                  WrMstLock_i,
  output logic                  WrMstWaitReq_o,
  // Avalon master
  output logic [ADDR_WIDTH-1:0] AvalonAddr_o,
  output logic                  AvalonRead_o,
  output logic                  AvalonWrite_o,
  output logic [BE_WIDTH-1:0]   AvalonByteEnable_o,
  output logic [DATA_WIDTH-1:0] AvalonWriteData_o,
  output logic                  AvalonLock_o,
  input  logic [DATA_WIDTH-1:0] AvalonReadData_i,
  input  logic                  AvalonWaitReq_i,
  // status
  output logic [1:0]            ArbGrant_o
);

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_GNT_RD = 2'b01;
  localparam logic [1:0] S_GNT_WR = 2'b10;

  localparam logic LAST_RD = 1'b0;
  localparam logic LAST_WR = 1'b1;

  localparam logic [7:0] HOLD_SAT = 8'(MAX_HOLD);
  localparam logic [8:0] HOLD_LIM = 9'(MAX_HOLD);

  logic [1:0] state_q, state_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       last_gnt_q, last_gnt_d;
  // Set for the single dead cycle after a side switch; the new owner's command is masked.
  logic       turn_q, turn_d;

  logic       gnt_rd, gnt_wr, active;
  logic       req_own, req_oth, cmpl, hit_max, lock_own;
  logic [7:0] hold_inc;
  logic [1:0] other_gnt;

  assign gnt_rd    = (state_q == S_GNT_RD);
  assign gnt_wr    = (state_q == S_GNT_WR);
  assign active    = (gnt_rd | gnt_wr) & ~turn_q;
  assign req_own   = gnt_rd ? RdMstRead_i  : WrMstWrite_i;
  assign req_oth   = gnt_rd ? WrMstWrite_i : RdMstRead_i;
  assign other_gnt = gnt_rd ? S_GNT_WR     : S_GNT_RD;
  assign cmpl      = active & req_own & ~AvalonWaitReq_i;
  assign hold_inc  = (hold_cnt_q >= HOLD_SAT) ? HOLD_SAT : hold_cnt_q + 8'd1;
  assign hit_max   = ({1'b0, hold_cnt_q} + 9'd1) >= HOLD_LIM;

`ifdef FC_ARB_LOCK_EN
  assign lock_own     = (gnt_rd & RdMstLock_i) | (gnt_wr & WrMstLock_i);
  assign AvalonLock_o = lock_own;
`else
  logic unused_lock;
  assign unused_lock  = RdMstLock_i ^ WrMstLock_i;
  assign lock_own     = 1'b0;
  assign AvalonLock_o = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    last_gnt_d = last_gnt_q;
    turn_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        hold_cnt_d = 8'd0;
        if (RdMstRead_i && WrMstWrite_i)
          state_d = (last_gnt_q == LAST_WR) ? S_GNT_RD : S_GNT_WR;
        else if (WrMstWrite_i)
          state_d = S_GNT_WR;
        else if (RdMstRead_i)
          state_d = S_GNT_RD;
      end
      S_GNT_RD, S_GNT_WR: begin
        if (turn_q) begin
          state_d = state_q;
        end else if (req_own) begin
          if (cmpl) begin
            if (req_oth && hit_max && !lock_own) begin
              state_d    = other_gnt;
              turn_d     = 1'b1;
              hold_cnt_d = 8'd0;
              last_gnt_d = gnt_wr ? LAST_WR : LAST_RD;
            end else begin
              hold_cnt_d = hold_inc;
            end
          end
        end else if (!lock_own) begin
          hold_cnt_d = 8'd0;
          last_gnt_d = gnt_wr ? LAST_WR : LAST_RD;
          if (req_oth) begin
            state_d = other_gnt;
            turn_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d    = S_IDLE;
        hold_cnt_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      hold_cnt_q <= 8'd0;
      last_gnt_q <= LAST_WR;
      turn_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      last_gnt_q <= last_gnt_d;
      turn_q     <= turn_d;
    end
  end

  // Command path is purely combinational from state, so reset drops it at once.
  assign AvalonAddr_o       = gnt_wr ? WrMstAddr_i : RdMstAddr_i;
  assign AvalonByteEnable_o = gnt_wr ? WrMstByteEnable_i : RdMstByteEnable_i;
  assign AvalonWriteData_o  = WrMstWriteData_i;
  assign AvalonRead_o       = active & gnt_rd & RdMstRead_i;
  assign AvalonWrite_o      = active & gnt_wr & WrMstWrite_i;

  assign RdMstWaitReq_o  = (active & gnt_rd) ? AvalonWaitReq_i : 1'b1;
  assign WrMstWaitReq_o  = (active & gnt_wr) ? AvalonWaitReq_i : 1'b1;
  assign RdMstReadData_o = AvalonReadData_i;
  assign ArbGrant_o      = state_q;

endmodule

// File: tb/tb_fullconnect_mst_arbiter.sv
// Random and directed bench for fullconnect_mst_arbiter: two instances (MAX_HOLD 8 and 1)
// share stimulus and are compared each cycle against an ownership/turnaround model.
module tb_fullconnect_mst_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rd_addr, wr_addr;
  logic          rd_req, wr_req, rd_lock, wr_lock, av_wait;
  logic [BW-1:0] rd_be, wr_be;
  logic [DW-1:0] wr_data, av_rdata;

  logic [DW-1:0] a_rdata, b_rdata, a_wdata, b_wdata;
  logic          a_rdwait, b_rdwait, a_wrwait, b_wrwait;
  logic [AW-1:0] a_addr, b_addr;
  logic          a_read, b_read, a_write, b_write, a_lock, b_lock;
  logic [BW-1:0] a_be, b_be;
  logic [1:0]    a_gnt, b_gnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fullconnect_mst_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .MAX_HOLD(8)) dut_a (
    .clk(clk), .rst(rst),
    .RdMstAddr_i(rd_addr), .RdMstRead_i(rd_req), .RdMstByteEnable_i(rd_be), .RdMstLock_i(rd_lock),
    .RdMstReadData_o(a_rdata), .RdMstWaitReq_o(a_rdwait),
    .WrMstAddr_i(wr_addr), .WrMstWrite_i(wr_req), .WrMstByteEnable_i(wr_be),
    .WrMstWriteData_i(wr_data), .WrMstLock_i(wr_lock), .WrMstWaitReq_o(a_wrwait),
    .AvalonAddr_o(a_addr), .AvalonRead_o(a_read), .AvalonWrite_o(a_write),
    .AvalonByteEnable_o(a_be), .AvalonWriteData_o(a_wdata), .AvalonLock_o(a_lock),
    .AvalonReadData_i(av_rdata), .AvalonWaitReq_i(av_wait), .ArbGrant_o(a_gnt));

  fullconnect_mst_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .MAX_HOLD(1)) dut_b (
    .clk(clk), .rst(rst),
    .RdMstAddr_i(rd_addr), .RdMstRead_i(rd_req), .RdMstByteEnable_i(rd_be), .RdMstLock_i(rd_lock),
    .RdMstReadData_o(b_rdata), .RdMstWaitReq_o(b_rdwait),
    .WrMstAddr_i(wr_addr), .WrMstWrite_i(wr_req), .WrMstByteEnable_i(wr_be),
    .WrMstWriteData_i(wr_data), .WrMstLock_i(wr_lock), .WrMstWaitReq_o(b_wrwait),
    .AvalonAddr_o(b_addr), .AvalonRead_o(b_read), .AvalonWrite_o(b_write),
    .AvalonByteEnable_o(b_be), .AvalonWriteData_o(b_wdata), .AvalonLock_o(b_lock),
    .AvalonReadData_i(av_rdata), .AvalonWaitReq_i(av_wait), .ArbGrant_o(b_gnt));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the bus (0 none, 1 read, 2 write), whether this is the dead
  // cycle after a hand-over, how many transfers the owner has done, who owned last.
  int m_own[2], m_turn[2], m_runs[2], m_last[2];
  int m_hold[2] = '{8, 1};

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_own[k] = 0; m_turn[k] = 0; m_runs[k] = 0; m_last[k] = 2;
      end else if (m_own[k] == 0) begin
        m_runs[k] = 0;
        if (rd_req && wr_req) m_own[k] = (m_last[k] == 2) ? 1 : 2;
        else if (wr_req)      m_own[k] = 2;
        else if (rd_req)      m_own[k] = 1;
      end else if (m_turn[k] != 0) begin
        m_turn[k] = 0;
      end else begin
        automatic bit mine  = (m_own[k] == 1) ? rd_req : wr_req;
        automatic bit other = (m_own[k] == 1) ? wr_req : rd_req;
        if (mine) begin
          if (!av_wait) begin
            m_runs[k]++;
            if (other && m_runs[k] >= m_hold[k]) begin
              m_last[k] = m_own[k]; m_own[k] = 3 - m_own[k]; m_turn[k] = 1; m_runs[k] = 0;
            end
          end
        end else begin
          m_last[k] = m_own[k]; m_runs[k] = 0;
          if (other) begin m_own[k] = 3 - m_own[k]; m_turn[k] = 1; end
          else m_own[k] = 0;
        end
      end
    end
  end

  task automatic cmp(input int k, input logic [1:0] gnt, input logic rd_o, input logic wr_o,
                     input logic rdw, input logic wrw, input logic [AW-1:0] addr,
                     input logic [BW-1:0] be, input logic [DW-1:0] rdat,
                     input logic [DW-1:0] wdat, input logic lock);
    bit act;
    act = (m_own[k] != 0) && (m_turn[k] == 0);
    check($sformatf("m%0d grant", k), gnt, m_own[k]);
    check($sformatf("m%0d read", k), rd_o, act && m_own[k] == 1 && rd_req);
    check($sformatf("m%0d write", k), wr_o, act && m_own[k] == 2 && wr_req);
    check($sformatf("m%0d rdwait", k), rdw, (act && m_own[k] == 1) ? av_wait : 1'b1);
    check($sformatf("m%0d wrwait", k), wrw, (act && m_own[k] == 2) ? av_wait : 1'b1);
    check($sformatf("m%0d rdata", k), rdat, av_rdata);
    check($sformatf("m%0d wdata", k), wdat, wr_data);
    check($sformatf("m%0d lock", k), lock, 1'b0);
    if (act) begin
      check($sformatf("m%0d addr", k), addr, (m_own[k] == 2) ? wr_addr : rd_addr);
      check($sformatf("m%0d be", k), be, (m_own[k] == 2) ? wr_be : rd_be);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      cmp(0, a_gnt, a_read, a_write, a_rdwait, a_wrwait, a_addr, a_be, a_rdata, a_wdata, a_lock);
      cmp(1, b_gnt, b_read, b_write, b_rdwait, b_wrwait, b_addr, b_be, b_rdata, b_wdata, b_lock);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rd_addr = '0; wr_addr = '0; rd_req = 0; wr_req = 0; rd_lock = 0; wr_lock = 0;
    rd_be = '0; wr_be = '0; wr_data = '0; av_rdata = '0; av_wait = 0;
    tick(); tick();
    check("rst grant", a_gnt, 2'b00);
    check("rst read", a_read, 1'b0);
    check("rst write", a_write, 1'b0);
    check("rst rdwait", a_rdwait, 1'b1);
    check("rst wrwait", a_wrwait, 1'b1);
    rst = 1'b0;

    // single read at 0x1000
    rd_req = 1; rd_addr = 16'h1000; rd_be = 4'hF; av_rdata = 32'hCAFE0001;
    tick();
    check("rd1 grant", a_gnt, 2'b01);
    check("rd1 read", a_read, 1'b1);
    check("rd1 addr", a_addr, 16'h1000);
    check("rd1 rdata", a_rdata, 32'hCAFE0001);
    check("rd1 rdwait", a_rdwait, 1'b0);
    rd_req = 0;
    tick();
    check("rd1 read drop", a_read, 1'b0);
    check("rd1 grant idle", a_gnt, 2'b00);

    // continuous contention: 8/1 alternation with one dead cycle between owners
    reset_pulse();
    rd_req = 1; wr_req = 1; av_wait = 0;
    for (int i = 0; i < 40; i++) begin
      int p, q;
      logic [1:0] ea, eb;
      tick();
      p = i % 18; q = i % 4;
      ea = (p < 8) ? 2'b01 : (p == 8 || p == 17) ? 2'b00 : 2'b10;
      eb = (q == 0) ? 2'b01 : (q == 2) ? 2'b10 : 2'b00;
      check($sformatf("hold8 cyc%0d", i), {a_write, a_read}, ea);
      check($sformatf("hold1 cyc%0d", i), {b_write, b_read}, eb);
    end

    // write stalled by waitrequest while read waits
    reset_pulse();
    rd_req = 0; wr_req = 1; wr_addr = 16'h2222; wr_data = 32'h5555AAAA; wr_be = 4'hA;
    tick();
    av_wait = 1; rd_req = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall write", a_write, 1'b1);
      check("stall addr", a_addr, 16'h2222);
      check("stall data", a_wdata, 32'h5555AAAA);
      check("stall be", a_be, 4'hA);
      check("stall grant", a_gnt, 2'b10);
      check("stall rdwait", a_rdwait, 1'b1);
    end
    av_wait = 0;
    tick();

    // lone write side: 20 back-to-back writes
    reset_pulse();
    rd_req = 0; wr_req = 1; av_wait = 0;
    tick();
    for (int i = 0; i < 20; i++) begin
      wr_addr = 16'(i + 16'h300);
      #1;
      check("burst write", a_write, 1'b1);
      check("burst addr", a_addr, 16'(i + 16'h300));
      check("burst grant", a_gnt, 2'b10);
      tick();
    end
    wr_req = 0;
    tick();

    // async reset during a stalled write
    reset_pulse();
    wr_req = 1; av_wait = 1;
    tick();
    check("arst pre write", a_write, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("arst write", a_write, 1'b0);
    check("arst grant", a_gnt, 2'b00);
    check("arst wrwait", a_wrwait, 1'b1);
    tick();
    rst = 1'b0; wr_req = 0; av_wait = 0;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      rd_req   = ($urandom_range(0, 99) < 70);
      wr_req   = ($urandom_range(0, 99) < 70);
      av_wait  = ($urandom_range(0, 99) < 25);
      rd_lock  = 1'($urandom);
      wr_lock  = 1'($urandom);
      rd_addr  = 16'($urandom);
      wr_addr  = 16'($urandom);
      rd_be    = 4'($urandom);
      wr_be    = 4'($urandom);
      wr_data  = $urandom;
      av_rdata = $urandom;
    end
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
